garage_door_input_conditioner: RTL

Front-end stage sitting directly upstream of the automatic garage door controller.
- Synchronises and debounces the raw push button and the two raw limit switches.
- Drives the controller's Activate, Up_Max and Dn_Max inputs with clean levels.
- Generates a one-cycle Activate_Pulse for logging and event counting.
- Flags a sensor fault when both limit switches read high for too long.

---
 rtl/garage_door_input_conditioner_if.sv | 28 ++
 rtl/garage_door_input_conditioner.sv | 99 +++++++++
 2 files changed

// File: rtl/garage_door_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : garage_door_input_conditioner_if
// Description : Raw switch inputs and clean controller-side outputs of the
//               garage door input conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
interface garage_door_input_conditioner_if;
    logic Btn_Raw;
    logic Up_Sw_Raw;
    logic Dn_Sw_Raw;
    logic Activate;
    logic Up_Max;
    logic Dn_Max;
    logic Activate_Pulse;
    logic Sensor_Fault;

    modport master (
        output Btn_Raw, Up_Sw_Raw, Dn_Sw_Raw,
        input  Activate, Up_Max, Dn_Max, Activate_Pulse, Sensor_Fault
    );

    modport slave (
        input  Btn_Raw, Up_Sw_Raw, Dn_Sw_Raw,
        output Activate, Up_Max, Dn_Max, Activate_Pulse, Sensor_Fault
    );
endinterface
`default_nettype wire

// File: rtl/garage_door_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : garage_door_input_conditioner
// Description : Synchronises and debounces the door button and limit switches,
//               emits an activate strobe and a both-limits-high fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
module garage_door_input_conditioner #(
    parameter int DEB_CYCLES   = 4,
    parameter int CNT_W        = 3,
    parameter int FAULT_CYCLES = 8,
    parameter int FCNT_W       = 4
) (
    input  wire logic                            CLK,
    input  wire logic                            RST,
    garage_door_input_conditioner_if.slave       bus
);
    localparam int                c_NCH       = 3;
    localparam logic [CNT_W-1:0]  c_DEB_MAX   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [FCNT_W-1:0] c_FAULT_MAX = FCNT_W'(FAULT_CYCLES);

    // Channel order: 0 = button, 1 = upper limit, 2 = lower limit
    logic [c_NCH-1:0]  w_raw;
    logic [c_NCH-1:0]  r_s1;
    logic [c_NCH-1:0]  r_s;
    logic [c_NCH-1:0]  w_clean;
    logic [c_NCH-1:0]  w_take;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_nxt;
    logic              w_both;
    logic              r_pulse;
    logic              r_fault;

    assign w_raw = {bus.Dn_Sw_Raw, bus.Up_Sw_Raw, bus.Btn_Raw};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1 <= '0;
            r_s  <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s  <= r_s1;
        end
    end

    generate
        for (genvar i = 0; i < c_NCH; i++) begin : g_chan
            logic [CNT_W-1:0] r_cnt;
            logic             r_clean;

            assign w_take[i]  = (r_s[i] != r_clean) && (r_cnt == c_DEB_MAX);
            assign w_clean[i] = r_clean;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_cnt   <= '0;
                    r_clean <= 1'b0;
                end else if (r_s[i] == r_clean) begin
                    r_cnt   <= '0;
                end else if (r_cnt == c_DEB_MAX) begin
                    r_clean <= r_s[i];
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign w_both = w_clean[1] & w_clean[2];

    // Fault flag tracks the next counter value so it sets on the same edge
    // the counter reaches its terminal count.
    always_comb begin
        w_fcnt_nxt = '0;
        if (w_both) begin
            w_fcnt_nxt = (r_fcnt == c_FAULT_MAX) ? r_fcnt : r_fcnt + FCNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fcnt  <= '0;
            r_fault <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_fcnt  <= w_fcnt_nxt;
            r_fault <= (w_fcnt_nxt == c_FAULT_MAX);
            r_pulse <= w_take[0] & r_s[0];
        end
    end

    assign bus.Activate       = w_clean[0];
    assign bus.Up_Max         = w_clean[1];
    assign bus.Dn_Max         = w_clean[2];
    assign bus.Activate_Pulse = r_pulse;
    assign bus.Sensor_Fault   = r_fault;
endmodule
`default_nettype wire
